// File: rtl/note_sequencer_if.sv
// note_sequencer_if: captured-note event handshake into the sequencer
// (valid/ready plus octave, note and length code).
interface note_sequencer_if #(
   parameter int unsigned OCT_W  = 3,
   parameter int unsigned NOTE_W = 3,
   parameter int unsigned LEN_W  = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [OCT_W-1:0]  in_octave;
   logic [NOTE_W-1:0] in_note;
   logic [LEN_W-1:0]  in_length;

   modport master (output in_valid, in_octave, in_note, in_length, input in_ready);
   modport slave  (input in_valid, in_octave, in_note, in_length, output in_ready);
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: FIFO-buffered note playback scheduler with pause and flush.
// Define NOTE_SEQ_REST_EN to treat note 0 as a silent rest.
module note_sequencer #(
   parameter  int unsigned DEPTH       = 8,
   parameter  int unsigned UNIT_CYCLES = 4,
   parameter  int unsigned GAP_CYCLES  = 2,
   parameter  int unsigned OCT_W       = 3,
   parameter  int unsigned NOTE_W      = 3,
   parameter  int unsigned LEN_W       = 3,
   localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   note_sequencer_if.slave   in_if,
   input  logic              pause,
   input  logic              flush,
   output logic              tone_on,
   output logic [OCT_W-1:0]  tone_octave,
   output logic [NOTE_W-1:0] tone_note,
   output logic              busy,
   output logic              note_done,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned DUR_W = LEN_W + $clog2(UNIT_CYCLES) + 1;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int unsigned TMR_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
   localparam int unsigned ENT_W = OCT_W + NOTE_W + LEN_W;

   typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [TMR_W-1:0]  timer_q;
   state_e            state_q;
   logic              rest_q;

   logic              push, pop, can_start, last_play, last_gap, head_rest;
   logic [OCT_W-1:0]  head_oct;
   logic [NOTE_W-1:0] head_note;
   logic [LEN_W-1:0]  head_len;
   logic [TMR_W-1:0]  head_dur;

   assign in_if.in_ready = (count != CNT_W'(DEPTH));
   assign push           = in_if.in_valid && in_if.in_ready && !flush;
   assign busy           = (state_q != StIdle);

   assign {head_oct, head_note, head_len} = mem_q[rd_ptr_q];
   assign head_dur = (TMR_W'(head_len) + TMR_W'(1)) * TMR_W'(UNIT_CYCLES);

`ifdef NOTE_SEQ_REST_EN
   assign head_rest = (head_note == '0);
`else
   assign head_rest = 1'b0;
`endif

   // Pops happen from IDLE, or on the final edge of GAP/PLAY so no idle cycle is lost.
   assign can_start = (count != '0) && !pause && !flush;
   assign last_play = (state_q == StPlay) && !pause && (timer_q == TMR_W'(1));
   assign last_gap  = (state_q == StGap) && !pause && (timer_q == TMR_W'(1));
   assign pop = can_start &&
                ((state_q == StIdle) || last_gap || (last_play && (GAP_CYCLES == 0)));

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_if.in_octave, in_if.in_note, in_if.in_length};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count       <= '0;
         state_q     <= StIdle;
         timer_q     <= '0;
         rest_q      <= 1'b0;
         tone_on     <= 1'b0;
         tone_octave <= '0;
         tone_note   <= '0;
         note_done   <= 1'b0;
      end else if (flush) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count       <= '0;
         state_q     <= StIdle;
         timer_q     <= '0;
         rest_q      <= 1'b0;
         tone_on     <= 1'b0;
         tone_octave <= '0;
         tone_note   <= '0;
         note_done   <= 1'b0;
      end else begin
         note_done <= last_play;
         count     <= count + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

         if (pop) begin
            state_q     <= StPlay;
            timer_q     <= head_dur;
            tone_octave <= head_oct;
            tone_note   <= head_note;
            tone_on     <= !head_rest;
            rest_q      <= head_rest;
         end else begin
            unique case (state_q)
               StIdle: ;
               StPlay: begin
                  if (pause) begin
                     tone_on <= 1'b0;
                  end else if (timer_q == TMR_W'(1)) begin
                     tone_on <= 1'b0;
                     if (GAP_CYCLES > 0) begin
                        state_q <= StGap;
                        timer_q <= TMR_W'(GAP_CYCLES);
                     end else begin
                        state_q <= StIdle;
                        timer_q <= '0;
                     end
                  end else begin
                     timer_q <= timer_q - TMR_W'(1);
                     tone_on <= !rest_q;
                  end
               end
               StGap: begin
                  if (!pause) begin
                     if (timer_q == TMR_W'(1)) begin
                        state_q <= StIdle;
                        timer_q <= '0;
                     end else begin
                        timer_q <= timer_q - TMR_W'(1);
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
